store_sequence_checker: RTL and testbench

Synthesizable monitor that sits directly downstream of the pipelined MIPS `top` data-memory write port (`memwrite`, `dataadr`, `writedata`). It compares every committed store against an ordered list of expected (address, data) pairs and tolerates stores to one scratch address. It reports a latched pass/fail verdict with error capture, so the self-check runs identically in simulation and on FPGA.

---
 rtl/store_sequence_checker.sv | 151 +++++++++++++++
 tb/tb_store_sequence_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_sequence_checker.sv
// store_sequence_checker: watches the data-memory write port of the
// pipelined MIPS core and checks every committed store against an ordered
// list of expected (address, data) pairs. Stores to one scratch address
// are skipped. The verdict (pass/fail/timeout) and the offending store are
// latched until reset, so the same self-check works in simulation and on FPGA.
module store_sequence_checker #(
  parameter int          NUM_CHECKS = 3,
  parameter logic [31:0] IGNORE_ADR = 32'd80,
  parameter int          TIMEOUT    = 1000,
  parameter int          CW         = $clog2(NUM_CHECKS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  input  logic [32*NUM_CHECKS-1:0]   exp_adr,
  input  logic [32*NUM_CHECKS-1:0]   exp_data,
  output logic [CW-1:0]              count,
  output logic [7:0]                 ignored,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic                       done,
  output logic [CW-1:0]              err_idx,
  output logic [31:0]                err_adr,
  output logic [31:0]                err_data
);

  localparam int CYCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      ignored_q, ignored_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   err_idx_q, err_idx_d;
  logic [31:0]     err_adr_q, err_adr_d;
  logic [31:0]     err_data_q, err_data_d;
  logic [CYCW-1:0] cyc_q, cyc_d;

  logic [31:0]     cur_adr_s;
  logic [31:0]     cur_data_s;
  logic            match_s;
  logic            ignore_s;

  // Select the expected pair for the current index.
  always_comb begin
    cur_adr_s  = 32'd0;
    cur_data_s = 32'd0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      cur_adr_s  = (count_q == CW'(i)) ? exp_adr[32*i +: 32]  : cur_adr_s;
      cur_data_s = (count_q == CW'(i)) ? exp_data[32*i +: 32] : cur_data_s;
    end
    match_s  = (dataadr == cur_adr_s) && (writedata == cur_data_s);
    ignore_s = (dataadr == IGNORE_ADR);
  end

  // Next-state: classify the store, then apply the timeout if still running.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ignored_d  = ignored_q;
    timeout_d  = timeout_q;
    err_idx_d  = err_idx_q;
    err_adr_d  = err_adr_q;
    err_data_d = err_data_q;
    cyc_d      = cyc_q;
    case (state_q)
      RUN: begin
        cyc_d = cyc_q + CYCW'(1);
        if (memwrite) begin
          if (match_s) begin
            count_d = count_q + CW'(1);
            if (count_d == CW'(NUM_CHECKS)) begin
              state_d = PASS;
            end else begin
              state_d = RUN;
            end
          end else if (ignore_s) begin
            if (ignored_q != 8'hFF) begin
              ignored_d = ignored_q + 8'd1;
            end else begin
              ignored_d = ignored_q;
            end
          end else begin
            state_d    = FAIL;
            err_idx_d  = count_q;
            err_adr_d  = dataadr;
            err_data_d = writedata;
            timeout_d  = 1'b0;
          end
        end else begin
          state_d = RUN;
        end
        // A verdict reached by the store on this edge wins over the timeout.
        if ((state_d == RUN) && (cyc_q == CYCW'(TIMEOUT - 1))) begin
          state_d    = FAIL;
          timeout_d  = 1'b1;
          err_idx_d  = count_d;
          err_adr_d  = 32'd0;
          err_data_d = 32'd0;
        end else begin
          timeout_d = timeout_d;
        end
      end
      PASS: state_d = PASS;
      FAIL: state_d = FAIL;
      default: state_d = FAIL;
    endcase
  end

  // State and result registers; reset restarts checking at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      count_q    <= '0;
      ignored_q  <= 8'd0;
      timeout_q  <= 1'b0;
      err_idx_q  <= '0;
      err_adr_q  <= 32'd0;
      err_data_q <= 32'd0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ignored_q  <= ignored_d;
      timeout_q  <= timeout_d;
      err_idx_q  <= err_idx_d;
      err_adr_q  <= err_adr_d;
      err_data_q <= err_data_d;
      cyc_q      <= cyc_d;
    end
  end

  assign count    = count_q;
  assign ignored  = ignored_q;
  assign pass     = (state_q == PASS);
  assign fail     = (state_q == FAIL);
  assign done     = pass | fail;
  assign timeout  = timeout_q;
  assign err_idx  = err_idx_q;
  assign err_adr  = err_adr_q;
  assign err_data = err_data_q;

endmodule

// File: tb/tb_store_sequence_checker.sv
// Directed bench for store_sequence_checker: expected list (84,7654),
// (40,36), (60,36) with scratch address 80. A second instance with
// TIMEOUT=20 covers the timeout path.
module tb_store_sequence_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [95:0] exp_adr;
  logic [95:0] exp_data;

  logic [1:0]  count, count2;
  logic [7:0]  ignored, ignored2;
  logic        pass, pass2, fail, fail2, timeout, timeout2, done, done2;
  logic [1:0]  err_idx, err_idx2;
  logic [31:0] err_adr, err_adr2, err_data, err_data2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_sequence_checker #(.NUM_CHECKS(3), .IGNORE_ADR(32'd80), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_adr(exp_adr), .exp_data(exp_data),
    .count(count), .ignored(ignored), .pass(pass), .fail(fail),
    .timeout(timeout), .done(done), .err_idx(err_idx), .err_adr(err_adr),
    .err_data(err_data)
  );

  store_sequence_checker #(.NUM_CHECKS(3), .IGNORE_ADR(32'd80), .TIMEOUT(20)) dut_to (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_adr(exp_adr), .exp_data(exp_data),
    .count(count2), .ignored(ignored2), .pass(pass2), .fail(fail2),
    .timeout(timeout2), .done(done2), .err_idx(err_idx2), .err_adr(err_adr2),
    .err_data(err_data2)
  );

  task automatic set_default_list();
    exp_adr  = {32'd60, 32'd40, 32'd84};
    exp_data = {32'd36, 32'd36, 32'd7654};
  endtask

  task automatic do_reset();
    @(negedge clk);
    memwrite = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One store sampled by a single rising edge; returns on the following negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(negedge clk);
    memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
  endtask

  task automatic test_reset();
    set_default_list();
    do_reset();
    checks++;
    if ({count, ignored, pass, fail, timeout, done, err_idx} !== 15'd0 ||
        err_adr !== 32'd0 || err_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: count=%0d ignored=%0d pass=%b fail=%b timeout=%b done=%b err_idx=%0d err_adr=%0d err_data=%0d, want all 0",
               count, ignored, pass, fail, timeout, done, err_idx, err_adr, err_data);
    end
  endtask

  task automatic test_pass_with_ignore();
    do_reset();
    store(32'd84, 32'd7654);
    store(32'd80, 32'd5);
    store(32'd40, 32'd36);
    checks++;
    if (count !== 2'd2 || ignored !== 8'd1 || pass !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL pass_mid: count=%0d ignored=%0d pass=%b fail=%b, want 2 1 0 0", count, ignored, pass, fail);
    end
    store(32'd60, 32'd36);
    checks++;
    if (count !== 2'd3 || ignored !== 8'd1 || pass !== 1'b1 || done !== 1'b1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL pass_end: count=%0d ignored=%0d pass=%b done=%b fail=%b, want 3 1 1 1 0",
               count, ignored, pass, done, fail);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    store(32'd84, 32'd7654);
    store(32'd40, 32'd35);
    checks++;
    if (fail !== 1'b1 || timeout !== 1'b0 || done !== 1'b1 || pass !== 1'b0 || count !== 2'd1) begin
      failures++;
      $display("FAIL mismatch_flags: fail=%b timeout=%b done=%b pass=%b count=%0d, want 1 0 1 0 1",
               fail, timeout, done, pass, count);
    end
    checks++;
    if (err_idx !== 2'd1 || err_adr !== 32'd40 || err_data !== 32'd35) begin
      failures++;
      $display("FAIL mismatch_capture: err_idx=%0d err_adr=%0d err_data=%0d, want 1 40 35", err_idx, err_adr, err_data);
    end
    // A later matching store must not revive the run.
    store(32'd40, 32'd36);
    checks++;
    if (fail !== 1'b1 || count !== 2'd1 || err_data !== 32'd35) begin
      failures++;
      $display("FAIL mismatch_hold: fail=%b count=%0d err_data=%0d, want 1 1 35", fail, count, err_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7654;
    @(negedge clk);
    dataadr = 32'd40; writedata = 32'd36;
    @(negedge clk);
    dataadr = 32'd60; writedata = 32'd36;
    @(negedge clk);
    memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
    checks++;
    if (pass !== 1'b1 || count !== 2'd3 || fail !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pass: pass=%b count=%0d fail=%b, want 1 3 0", pass, count, fail);
    end
    store(32'd0, 32'd0);
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0 || done !== 1'b1 || count !== 2'd3 || ignored !== 8'd0 ||
        timeout !== 1'b0 || err_idx !== 2'd0 || err_adr !== 32'd0 || err_data !== 32'd0) begin
      failures++;
      $display("FAIL pass_hold: pass=%b fail=%b done=%b count=%0d ignored=%0d timeout=%b err_idx=%0d err_adr=%0d err_data=%0d, want 1 0 1 3 0 0 0 0 0",
               pass, fail, done, count, ignored, timeout, err_idx, err_adr, err_data);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    // Store sampled at the first edge after reset release.
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7654;
    @(negedge clk);
    memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
    repeat (17) @(negedge clk);
    checks++;
    if (fail2 !== 1'b0 || count2 !== 2'd1 || timeout2 !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: fail=%b count=%0d timeout=%b after 18 edges, want 0 1 0", fail2, count2, timeout2);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fail2 !== 1'b1 || timeout2 !== 1'b1 || done2 !== 1'b1 || err_idx2 !== 2'd1 ||
        err_adr2 !== 32'd0 || err_data2 !== 32'd0) begin
      failures++;
      $display("FAIL timeout_fire: fail=%b timeout=%b done=%b err_idx=%0d err_adr=%0d err_data=%0d, want 1 1 1 1 0 0",
               fail2, timeout2, done2, err_idx2, err_adr2, err_data2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    store(32'd84, 32'd7654);
    store(32'd40, 32'd36);
    checks++;
    if (count !== 2'd2) begin
      failures++;
      $display("FAIL pre_reset_count: count=%0d, want 2", count);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 2'd0 || pass !== 1'b0 || fail !== 1'b0 || done !== 1'b0 || ignored !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: count=%0d pass=%b fail=%b done=%b ignored=%0d, want all 0",
               count, pass, fail, done, ignored);
    end
    @(negedge clk);
    reset = 1'b0;
    store(32'd84, 32'd7654);
    store(32'd40, 32'd36);
    store(32'd60, 32'd36);
    checks++;
    if (pass !== 1'b1 || count !== 2'd3) begin
      failures++;
      $display("FAIL rerun_pass: pass=%b count=%0d, want 1 3", pass, count);
    end
  endtask

  task automatic test_match_beats_ignore();
    exp_adr  = {32'd60, 32'd40, 32'd80};
    exp_data = {32'd36, 32'd36, 32'd9};
    do_reset();
    store(32'd80, 32'd9);
    checks++;
    if (count !== 2'd1 || ignored !== 8'd0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL match_priority: count=%0d ignored=%0d fail=%b, want 1 0 0", count, ignored, fail);
    end
    store(32'd80, 32'd4);
    checks++;
    if (count !== 2'd1 || ignored !== 8'd1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL ignore_after: count=%0d ignored=%0d fail=%b, want 1 1 0", count, ignored, fail);
    end
    set_default_list();
  endtask

  initial begin
    test_reset();
    test_pass_with_ignore();
    test_mismatch();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    test_match_beats_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
